sobel_stream_pipe: RTL
======================

// Module: sobel_stream_pipe
// PURPOSE
//  Streaming 3x3 Sobel edge detector for raster-order pixels, IMG_W x IMG_H per frame.
//  Generalised successor of the fixed 128-wide 8-bit Sobel block: parametrised size and depth,
//  ready/valid backpressure on both sides, L1/MAX magnitude, optional binary threshold, and
//  row/frame markers. Sits between the pixel source (camera/DMA) and the edge-map sink.
// PARAMETERS
//  IMG_W   128  pixels per row (>=3)
//  IMG_H   128  rows per frame (>=3)
//  PIX_W   8    bits per pixel, input and output
// PORTS
//  clk            in   1      clock
//  rst            in   1      synchronous, active-high reset
//  s_valid        in   1      input pixel valid
//  s_ready        out  1      block can accept a pixel
//  s_data         in   PIX_W  input pixel, unsigned, raster order
//  m_valid        out  1      output pixel valid
//  m_ready        in   1      sink accepts output
//  m_data         out  PIX_W  edge magnitude, or 0/all-ones in threshold mode
//  m_eol          out  1      last output of an output row
//  m_last         out  1      last output of the frame
//  cfg_mag_max    in   1      0: |gx|+|gy|; 1: max(|gx|,|gy|)
//  cfg_thresh_en  in   1      1: binary output
//  cfg_threshold  in   PIX_W  threshold, compared against clamped magnitude
// BEHAVIOUR
//  - Reset: col/row counters 0, all stage valids 0, m_valid/m_eol/m_last 0, m_data 0,
//    window registers 0. Line buffer RAM is not reset.
//  - Transfer: input beat on s_valid&&s_ready; output beat on m_valid&&m_ready.
//  - Stall = m_valid && !m_ready. While stalled, every stage holds, m_data/m_eol/m_last are stable.
//  - s_ready = !stall, combinational from m_ready. s_ready is 1 out of reset.
//  - Empty stages (bubbles) advance when not stalled. A gap in s_valid creates a bubble, not a stall.
//  - Counters advance only on input beats. col wraps IMG_W-1->0 and increments row.
//    row wraps IMG_H-1->0, which starts a new frame.
//  - Two line buffers, IMG_W x PIX_W each. Read-before-write at address col.
//    Buffer 1 holds row r-1, buffer 2 holds row r-2. Window is 3x3 shift registers.
//  - A window is emitted only for interior centres: accepted pixel has row>=2 && col>=2.
//    Output centre = (row-1, col-1). No border outputs: exactly (IMG_W-2)*(IMG_H-2) per frame.
//  - Kernels: gx = right col - left col, centre row weighted x2;
//    gy = top row - bottom row, centre col weighted x2.
//  - gx and gy are signed, GRAD_W = PIX_W+4 bits. abs values and the L1 sum are unsigned GRAD_W.
//    No overflow is possible.
//  - Clamp: mag > 2^PIX_W-1 gives all-ones, else mag[PIX_W-1:0].
//  - Threshold mode: m_data = (clamped >= cfg_threshold) ? all-ones : 0.
//  - Latency: an input beat completing a window at cycle t gives m_valid at t+3 with no stalls.
//    Stages: S1 window+gx/gy, S2 abs+magnitude, S3 clamp/threshold into output register.
//  - cfg_* is sampled into shadow registers on the input beat at (row 0, col 0).
//    A cfg change mid-frame has no effect until the next frame.
//  - m_eol is set with the output whose input col == IMG_W-1.
//    m_last is set with the output whose input is (IMG_H-1, IMG_W-1). m_last implies m_eol.
//  - Frame wrap: a new frame's first pixel may be accepted the cycle after the previous last pixel.
//    The in-flight last output still drains correctly. Rows 0-1 of the new frame produce no outputs.
//  - Reset mid-frame: all in-flight outputs are discarded. The next input beat is pixel (0,0).
// STRUCTURE
//  - sobel_pkg: GRAD_W function of PIX_W, MAG_L1/MAG_MAX constants, clog2-based counter widths.
//  - Sub-module sobel_line_buffer: one IMG_W x PIX_W read-before-write RAM with enable.
//    Instantiated twice and chained (buffer 1 read data feeds buffer 2 write data).
//  - Top level holds counters, window, 3-stage datapath with valid/marker sidebands,
//    stall logic and cfg shadow registers.
// TESTING (IMG_W=8, IMG_H=6, PIX_W=8 unless stated)
//  1. Flat frame, all 100, m_ready=1 -> 24 outputs all 0; m_eol on every 6th; m_last on the 24th only.
//  2. Vertical step, cols 0-3=0 and cols 4-7=255, L1 -> out cols 3,4 = 255 (gx=1020 clamped);
//     all other outputs 0.
//  3. Ramp pix=10*col, cfg_mag_max=1, thresh_en=1 -> threshold 80: all 255; threshold 81: all 0.
//     Unthresholded output: all 80.
//  4. Frame 2 with random s_valid gaps and m_ready low 10 cycles mid-row -> output sequence
//     identical to frame 1; m_data stable and s_ready=0 while stalled.
//  5. rst after 20 input beats, then a full frame -> m_valid=0 the cycle after rst;
//     exactly 24 outputs, matching test 1.
//  6. Back-to-back frames, cfg_thresh_en toggled mid-frame 1 -> frame 1 unaffected;
//     frame 2 uses the new cfg.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared constants and width helpers for the streaming Sobel edge detector.
package sobel_pkg;

  localparam logic MAG_L1  = 1'b0;
  localparam logic MAG_MAX = 1'b1;

  // Signed gradient width: |gx| <= 4*(2^PIX_W-1) and the L1 sum both fit in PIX_W+4 bits.
  function automatic int unsigned grad_w(input int unsigned pix_w);
    return pix_w + 4;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? unsigned'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One row of pixel history: read-before-write RAM, combinational read at addr_i.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned DATA_W = 8,
  localparam int unsigned ADDR_W = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] rd_data_c
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  assign rd_data_c = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (en_i) mem_q[addr_i] <= wr_data_i;
  end

endmodule

// File: rtl/sobel_stream_pipe.sv
// Streaming 3x3 Sobel edge detector with ready/valid flow control and row/frame markers.
module sobel_stream_pipe
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_W = 128,
  parameter int unsigned IMG_H = 128,
  parameter int unsigned PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [PIX_W-1:0] m_data,
  output logic             m_eol,
  output logic             m_last,
  input  logic             cfg_mag_max,
  input  logic             cfg_thresh_en,
  input  logic [PIX_W-1:0] cfg_threshold
);

  localparam int unsigned GRAD_W = grad_w(PIX_W);
  localparam int unsigned COL_W  = cnt_w(IMG_W);
  localparam int unsigned ROW_W  = cnt_w(IMG_H);
  localparam logic [PIX_W-1:0] PIX_MAX = '1;

  function automatic logic signed [GRAD_W-1:0] ext(input logic [PIX_W-1:0] p);
    return signed'(GRAD_W'(p));
  endfunction

  logic stall, adv, in_fire;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic col_last, row_last, emit_c;

  logic             mag_max_sh_q, th_en_sh_q;
  logic [PIX_W-1:0] th_sh_q;

  logic [PIX_W-1:0] lb1_rd, lb2_rd;
  logic [2:0][2:0][PIX_W-1:0] win_q, win_d;
  logic signed [GRAD_W-1:0] gx_d, gy_d;

  logic                     s1_valid_q, s1_eol_q, s1_last_q, s1_mag_max_q, s1_th_en_q;
  logic signed [GRAD_W-1:0] s1_gx_q, s1_gy_q;
  logic [PIX_W-1:0]         s1_th_q;

  logic [GRAD_W-1:0] ax_c, ay_c, mag_d;
  logic              s2_valid_q, s2_eol_q, s2_last_q, s2_th_en_q;
  logic [GRAD_W-1:0] s2_mag_q;
  logic [PIX_W-1:0]  s2_th_q;

  logic [PIX_W-1:0] clamp_c, out_d;
  logic             m_valid_q, m_eol_q, m_last_q;
  logic [PIX_W-1:0] m_data_q;

  // Whole pipeline freezes only while a valid output is refused by the sink.
  assign stall   = m_valid_q && !m_ready;
  assign adv     = !stall;
  assign s_ready = adv;
  assign in_fire = s_valid && adv;

  assign col_last = (col_q == COL_W'(IMG_W - 1));
  assign row_last = (row_q == ROW_W'(IMG_H - 1));
  assign emit_c   = in_fire && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (in_fire) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      mag_max_sh_q <= 1'b0;
      th_en_sh_q   <= 1'b0;
      th_sh_q      <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      if (in_fire && (col_q == '0) && (row_q == '0)) begin
        mag_max_sh_q <= cfg_mag_max;
        th_en_sh_q   <= cfg_thresh_en;
        th_sh_q      <= cfg_threshold;
      end
    end
  end

  // Buffer 1 holds row r-1; its read data is row r-2's successor written into buffer 2.
  sobel_line_buffer #(.DEPTH(IMG_W), .DATA_W(PIX_W)) u_lb1 (
    .clk       (clk),
    .en_i      (in_fire),
    .addr_i    (col_q),
    .wr_data_i (s_data),
    .rd_data_c (lb1_rd)
  );

  sobel_line_buffer #(.DEPTH(IMG_W), .DATA_W(PIX_W)) u_lb2 (
    .clk       (clk),
    .en_i      (in_fire),
    .addr_i    (col_q),
    .wr_data_i (lb1_rd),
    .rd_data_c (lb2_rd)
  );

  // Window rows: 0 = oldest (top), 2 = current (bottom); column 2 is newest.
  always_comb begin
    win_d = win_q;
    if (in_fire) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb2_rd;
      win_d[1][2] = lb1_rd;
      win_d[2][2] = s_data;
    end
  end

  always_comb begin
    gx_d = (ext(win_d[0][2]) + (ext(win_d[1][2]) <<< 1) + ext(win_d[2][2]))
         - (ext(win_d[0][0]) + (ext(win_d[1][0]) <<< 1) + ext(win_d[2][0]));
    gy_d = (ext(win_d[0][0]) + (ext(win_d[0][1]) <<< 1) + ext(win_d[0][2]))
         - (ext(win_d[2][0]) + (ext(win_d[2][1]) <<< 1) + ext(win_d[2][2]));
  end

  // Stage 1: window and gradients; cfg travels with the data so frame wraps drain cleanly.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_eol_q     <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_gx_q      <= '0;
      s1_gy_q      <= '0;
      s1_mag_max_q <= 1'b0;
      s1_th_en_q   <= 1'b0;
      s1_th_q      <= '0;
    end else if (adv) begin
      win_q        <= win_d;
      s1_valid_q   <= emit_c;
      s1_eol_q     <= col_last;
      s1_last_q    <= col_last && row_last;
      s1_gx_q      <= gx_d;
      s1_gy_q      <= gy_d;
      s1_mag_max_q <= mag_max_sh_q;
      s1_th_en_q   <= th_en_sh_q;
      s1_th_q      <= th_sh_q;
    end
  end

  always_comb begin
    ax_c  = s1_gx_q[GRAD_W-1] ? GRAD_W'(-s1_gx_q) : GRAD_W'(s1_gx_q);
    ay_c  = s1_gy_q[GRAD_W-1] ? GRAD_W'(-s1_gy_q) : GRAD_W'(s1_gy_q);
    mag_d = (s1_mag_max_q == MAG_L1) ? (ax_c + ay_c) : ((ax_c > ay_c) ? ax_c : ay_c);
  end

  // Stage 2: magnitude.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_eol_q   <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_mag_q   <= '0;
      s2_th_en_q <= 1'b0;
      s2_th_q    <= '0;
    end else if (adv) begin
      s2_valid_q <= s1_valid_q;
      s2_eol_q   <= s1_eol_q;
      s2_last_q  <= s1_last_q;
      s2_mag_q   <= mag_d;
      s2_th_en_q <= s1_th_en_q;
      s2_th_q    <= s1_th_q;
    end
  end

  always_comb begin
    clamp_c = (s2_mag_q > GRAD_W'(PIX_MAX)) ? PIX_MAX : s2_mag_q[PIX_W-1:0];
    out_d   = clamp_c;
    if (s2_th_en_q) out_d = (clamp_c >= s2_th_q) ? PIX_MAX : '0;
  end

  // Stage 3: clamp/threshold into the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_eol_q   <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
    end else if (adv) begin
      m_valid_q <= s2_valid_q;
      m_eol_q   <= s2_eol_q;
      m_last_q  <= s2_last_q;
      m_data_q  <= out_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_eol   = m_eol_q;
  assign m_last  = m_last_q;

endmodule
